// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with registered Sum/Co/Ovf and a valid strobe.
// Optional: define RCA_IN_REG_EN to register the operands before the carry chain (latency 2).
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] Aarr,
  input  logic [WIDTH-1:0] Barr,
  input  logic             C,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Co,
  output logic             Ovf
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             valid;

`ifdef RCA_IN_REG_EN
  // Input stage cut: reset clears it so a discarded operation never reaches the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a     <= '0;
      b     <= '0;
      cin   <= 1'b0;
      valid <= 1'b0;
    end else begin
      a     <= Aarr;
      b     <= Barr;
      cin   <= C;
      valid <= in_valid;
    end
  end
`else
  assign a     = Aarr;
  assign b     = Barr;
  assign cin   = C;
  assign valid = in_valid;
`endif

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;

  assign carry[0] = cin;

  // One explicit full-adder cell per bit; carry[i] is the carry into bit i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_c[i]   = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign ovf_c = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Co        <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      out_valid <= valid;
      if (valid) begin
        Sum <= sum_c;
        Co  <= carry[WIDTH];
        Ovf <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder (WIDTH=4); expected results are queued at drive time.
// Honours RCA_IN_REG_EN to expect the 2-cycle latency build.
module tb_ripple_carry_adder;

  localparam int WIDTH = 4;
`ifdef RCA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] Aarr;
  logic [WIDTH-1:0] Barr;
  logic             C;
  logic             out_valid;
  logic [WIDTH-1:0] Sum;
  logic             Co;
  logic             Ovf;

  exp_t sb[$];
  exp_t last_exp;
  int   total = 0;
  int   bad   = 0;

  ripple_carry_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .Aarr      (Aarr),
    .Barr      (Barr),
    .C         (C),
    .out_valid (out_valid),
    .Sum       (Sum),
    .Co        (Co),
    .Ovf       (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer add, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c);
    exp_t e;
    logic [WIDTH:0] full;
    full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    e.sum = full[WIDTH-1:0];
    e.co  = full[WIDTH];
    e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Scoreboard consumer: every out_valid pulse must match the oldest queued result.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_out_valid: got Sum=%b Co=%b with nothing pending", Sum, Co);
      end else begin
        e = sb.pop_front();
        last_exp = e;
        if (Sum !== e.sum) begin
          bad++;
          $display("[TB] FAIL sb_sum: got %b want %b", Sum, e.sum);
        end
        total++;
        if (Co !== e.co) begin
          bad++;
          $display("[TB] FAIL sb_co: got %b want %b", Co, e.co);
        end
        total++;
        if (Ovf !== e.ovf) begin
          bad++;
          $display("[TB] FAIL sb_ovf: got %b want %b", Ovf, e.ovf);
        end
      end
    end
  end

  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input exp_t e);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    Aarr     = a;
    Barr     = b;
    C        = c;
    sb.push_back(e);
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drain: got %0d results pending want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    Aarr     = 4'b1111;
    Barr     = 4'b1111;
    C        = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      total += 4;
      if (Sum !== 4'b0000) begin bad++; $display("[TB] FAIL reset_sum: got %b want 0000", Sum); end
      if (Co !== 1'b0) begin bad++; $display("[TB] FAIL reset_co: got %b want 0", Co); end
      if (Ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", Ovf); end
      if (out_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_valid: got %b want 0", out_valid);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_basic();
    drive_op(4'b0001, 4'b0010, 1'b0, '{sum: 4'b0011, co: 1'b0, ovf: 1'b0});
    drive_op(4'b0001, 4'b0010, 1'b1, '{sum: 4'b0100, co: 1'b0, ovf: 1'b0});
    drive_op(4'b0000, 4'b0000, 1'b1, '{sum: 4'b0001, co: 1'b0, ovf: 1'b0});
    go_idle();
    drain("basic");
  endtask

  task automatic test_carry_out();
    drive_op(4'b1010, 4'b1100, 1'b1, '{sum: 4'b0111, co: 1'b1, ovf: 1'b1});
    drive_op(4'b1010, 4'b1100, 1'b0, '{sum: 4'b0110, co: 1'b1, ovf: 1'b1});
    drive_op(4'b1111, 4'b1010, 1'b0, '{sum: 4'b1001, co: 1'b1, ovf: 1'b0});
    drive_op(4'b1111, 4'b1010, 1'b1, '{sum: 4'b1010, co: 1'b1, ovf: 1'b0});
    go_idle();
    drain("carry");
  endtask

  task automatic test_full_ripple();
    drive_op(4'b1111, 4'b0000, 1'b1, '{sum: 4'b0000, co: 1'b1, ovf: 1'b0});
    drive_op(4'b0111, 4'b0000, 1'b1, '{sum: 4'b1000, co: 1'b0, ovf: 1'b1});
    go_idle();
    drain("ripple");
  endtask

  task automatic test_latency();
    int cyc;
    drive_op(4'b0101, 4'b0011, 1'b0, model(4'b0101, 4'b0011, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 6) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (cyc != LAT) begin
      bad++;
      $display("[TB] FAIL latency: got %0d cycles want %0d", cyc, LAT);
    end
    drain("latency");
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < 16; i++) begin
      v = WIDTH'(i);
      drive_op(v, v, v[0], model(v, v, v[0]));
    end
    go_idle();
    drain("stream");
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_valid: got %b want 0", out_valid);
    end
    if (Sum !== last_exp.sum) begin
      bad++;
      $display("[TB] FAIL hold_sum: got %b want %b", Sum, last_exp.sum);
    end
    if (Co !== last_exp.co) begin
      bad++;
      $display("[TB] FAIL hold_co: got %b want %b", Co, last_exp.co);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    e = model(4'b0011, 4'b0101, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    Aarr     = 4'b0011;
    Barr     = 4'b0101;
    C        = 1'b1;
    // Single-cycle build shows the result before reset lands; the registered-input build drops it.
    if (LAT == 1) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    total += 4;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_valid: got %b want 0", out_valid);
    end
    if (Sum !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_sum: got %b want 0000", Sum); end
    if (Co !== 1'b0) begin bad++; $display("[TB] FAIL midrst_co: got %b want 0", Co); end
    if (Ovf !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ovf: got %b want 0", Ovf); end
    repeat (4) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL midrst_pending: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_out();
    test_full_ripple();
    test_latency();
    test_back_to_back();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
